// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit that writes the HI/LO registers.
// The unit computes one result bit per cycle: WIDTH cycles of CALC, then one FIX cycle
// that applies signs and writes HI/LO.
// The stall output holds back MFHI/MFLO in EX until a pending result has been written.
// Build option MDU_DIV_EN: when defined, the restoring divider is included.
// When MDU_DIV_EN is undefined, a start with op[1] = 1 is ignored and
// o_div_by_zero is tied to 0.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_rd_hilo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient bits}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b_mag;
    logic               r_neg_q;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_op_ok;
    logic               w_accept;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mstep;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

`ifdef MDU_DIV_EN
    logic               r_is_div;
    logic               r_neg_r;
    logic               r_b_zero;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_dtrial;
    logic [2*WIDTH-1:0] w_dstep;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_fix_dbz;
`endif

    // Operand signs only matter for the signed ops (op[0] = 1).
    assign w_a_neg = i_op[0] & i_a[WIDTH-1];
    assign w_b_neg = i_op[0] & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

`ifdef MDU_DIV_EN
    assign w_op_ok = 1'b1;
`else
    assign w_op_ok = ~i_op[1];
`endif

    assign w_accept = (r_state == S_IDLE) & i_start & w_op_ok;

    // Hold MFHI/MFLO while a result is pending or about to be started.
    assign o_stall = i_rd_hilo & (r_busy | (i_start & ~r_busy));

    // Shift-add step: add the multiplicand when the current multiplier bit is set.
    assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});
    assign w_mstep = {w_msum, r_acc[WIDTH-1:1]};
    assign w_prod  = r_neg_q ? -r_acc : r_acc;

`ifdef MDU_DIV_EN
    // Restoring step: shift in the next dividend bit.
    // Keep the subtraction only when it does not borrow.
    assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_dtrial = w_dshift - {1'b0, r_b_mag};
    assign w_dstep  = w_dtrial[WIDTH]
                    ? {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_quot   = r_acc[WIDTH-1:0];
    assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
    assign w_step   = r_is_div ? w_dstep : w_mstep;
`else
    assign w_step   = w_mstep;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the sign-corrected values that FIX writes into HI/LO.
    always_comb begin
        w_state_next = r_state;
        w_fix_hi     = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo     = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        w_fix_dbz    = 1'b0;
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fix_hi  = r_a_raw;
                w_fix_lo  = {WIDTH{1'b1}};
                w_fix_dbz = 1'b1;
            end else begin
                w_fix_lo  = r_neg_q ? -w_quot : w_quot;
                w_fix_hi  = r_neg_r ? -w_rem : w_rem;
            end
        end
`endif
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (r_count == CW'(1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on start, iterate in CALC, commit HI/LO in FIX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_b_mag  <= '0;
            r_neg_q  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_dbz    <= 1'b0;
            r_a_raw  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b_mag  <= w_b_mag;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_count  <= CW'(WIDTH);
                        r_busy   <= 1'b1;
`ifdef MDU_DIV_EN
                        r_is_div <= i_op[1];
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= (i_b == '0);
                        r_a_raw  <= i_a;
                        r_dbz    <= 1'b0;
`endif
                    end
                end
                S_CALC: begin
                    r_acc   <= w_step;
                    r_count <= r_count - CW'(1);
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
`ifdef MDU_DIV_EN
                    r_dbz  <= w_fix_dbz;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
`ifdef MDU_DIV_EN
    assign o_div_by_zero = r_dbz;
`else
    assign o_div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32).
// Follows MDU_DIV_EN in the same way as the design: it exercises divides when the
// macro is defined and checks that they are ignored when it is not.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         rd_hilo = 1'b0;
    logic         busy, done, dbz, stall;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    // Architectural HI/LO as the bench expects them to be.
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_op          (op),
        .i_a           (a),
        .i_b           (b),
        .i_rd_hilo     (rd_hilo),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz),
        .o_hi          (hi),
        .o_lo          (lo),
        .o_stall       (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic void model(input logic [1:0] op_i, input logic [W-1:0] a_i,
                                  input logic [W-1:0] b_i, output logic [W-1:0] h,
                                  output logic [W-1:0] l, output logic d);
        logic [63:0] p;
        longint      sp;
        int          sa, sb;
        d = 1'b0;
        h = '0;
        l = '0;
        case (op_i)
            2'd0: begin
                p = {32'b0, a_i} * {32'b0, b_i};
                h = p[63:32];
                l = p[31:0];
            end
            2'd1: begin
                sp = longint'($signed(a_i)) * longint'($signed(b_i));
                p  = 64'(sp);
                h  = p[63:32];
                l  = p[31:0];
            end
            2'd2: begin
                if (b_i == 0) begin
                    h = a_i; l = '1; d = 1'b1;
                end else begin
                    l = a_i / b_i;
                    h = a_i % b_i;
                end
            end
            default: begin
                if (b_i == 0) begin
                    h = a_i; l = '1; d = 1'b1;
                end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    h = '0; l = 32'h8000_0000;
                end else begin
                    sa = $signed(a_i);
                    sb = $signed(b_i);
                    l  = 32'(sa / sb);
                    h  = 32'(sa % sb);
                end
            end
        endcase
    endfunction

    // Issue one operation from a post-edge point, then wait (bounded) for done.
    task automatic do_op(input logic [1:0] op_i, input logic [W-1:0] a_i,
                         input logic [W-1:0] b_i, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dbz,
                         input string name);
        int cyc;
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < W + 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b after %0d edges",
                 name, op_i, a_i, b_i, hi, lo, dbz, cyc);
        n_checks++;
        if (cyc != W + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, W + 1);
        end
        n_checks++;
        if (hi !== exp_hi) begin
            n_fail++;
            $display("FAIL %s hi: got %h want %h", name, hi, exp_hi);
        end
        n_checks++;
        if (lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s lo: got %h want %h", name, lo, exp_lo);
        end
        n_checks++;
        if (dbz !== exp_dbz) begin
            n_fail++;
            $display("FAIL %s div_by_zero: got %b want %b", name, dbz, exp_dbz);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, dbz, stall} !== 4'b0000 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b stall=%b hi=%h lo=%h want all 0",
                     busy, done, dbz, stall, hi, lo);
        end
        $display("txn reset hi=%h lo=%h busy=%b", hi, lo, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_directed();
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL multu_max done_one_cycle: got %b want 0", done);
        end
        do_op(2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_neg");
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div_directed();
        do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
        do_op(2'd2, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, "divu_by_zero");
        do_op(2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_clears_dbz");
        do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "div_overflow");
    endtask
`else
    task automatic test_div_disabled();
        for (int t = 2; t <= 3; t++) begin
            start = 1'b1; op = 2'(t); a = 32'd100; b = 32'd7;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < W + 3; k++) begin
                n_checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL div_disabled op%0d cycle %0d: got busy=%b done=%b want 0 0",
                             t, k, busy, done);
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if (hi !== last_hi || lo !== last_lo || dbz !== 1'b0) begin
                n_fail++;
                $display("FAIL div_disabled op%0d hilo: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=0",
                         t, hi, lo, dbz, last_hi, last_lo);
            end
            $display("txn div_disabled op=%0d ignored hi=%h lo=%h", t, hi, lo);
        end
    endtask
`endif

    task automatic test_busy_stall();
        logic exp;
        rd_hilo = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: got %b want 0", stall);
        end
        start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd6;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_start_cycle: got %b want 1", stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= W + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            exp = (k <= W);
            n_checks++;
            if (busy !== exp || stall !== exp || done !== (k == W + 1)) begin
                n_fail++;
                $display("FAIL busy_stall edge %0d: got busy=%b stall=%b done=%b want %b %b %b",
                         k, busy, stall, done, exp, exp, (k == W + 1));
            end
            if (k == W + 1) begin
                n_checks++;
                if (lo !== 32'd42 || hi !== 32'd0) begin
                    n_fail++;
                    $display("FAIL busy_ignore result: got hi=%h lo=%h want 0 0000002a", hi, lo);
                end
            end
            // A second start sampled at edge 5 must be ignored.
            start = (k == 4);
            a = 32'd1; b = 32'd1;
        end
        start = 1'b0;
        rd_hilo = 1'b0;
        last_hi = 32'd0;
        last_lo = 32'd42;
        $display("txn busy_stall 7x6 with ignored start -> lo=%h", lo);
    endtask

    task automatic test_reset_midop();
        start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop state: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0",
                     hi, lo, busy, done);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_midop aborted cycle %0d: got done=%b busy=%b want 0 0",
                         k, done, busy);
            end
        end
        $display("txn reset_midop aborted hi=%h lo=%h", hi, lo);
        last_hi = '0;
        last_lo = '0;
        do_op(2'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "after_reset_3x4");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eh, el;
        logic         ed;
        logic [1:0]   o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 4; i++) begin
`ifdef MDU_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            x = $urandom;
            y = $urandom;
            model(o, x, y, eh, el, ed);
            // Called right after the previous done edge: start lands in the done cycle.
            do_op(o, x, y, eh, el, ed, "back_to_back");
        end
    endtask

    task automatic test_random();
        logic [W-1:0] eh, el;
        logic         ed;
        logic [1:0]   o;
        logic [W-1:0] x, y;
        int           sel;
        for (int i = 0; i < 40; i++) begin
`ifdef MDU_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            x = $urandom;
            y = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: y = '0;
                1: y = 32'($urandom_range(1, 15));
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: begin x = -32'($urandom_range(1, 1000)); y = 32'($urandom_range(1, 50)); end
                default: ;
            endcase
            model(o, x, y, eh, el, ed);
            do_op(o, x, y, eh, el, ed, "random");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
`ifdef MDU_DIV_EN
        test_div_directed();
`else
        test_div_disabled();
`endif
        test_busy_stall();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the pipelined MIPS core, sitting beside the EX-stage ALU and shifter. It executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers over multiple cycles, using a start/busy/done handshake. It raises a stall request when an MFHI/MFLO in EX would read HI/LO before a pending result lands. Operand width is parametrised.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  input  WIDTH  multiplicand / dividend (rs); sampled with start.
- b  input  WIDTH  multiplier / divisor (rt); sampled with start.
- rd_hilo  input  1  EX stage holds MFHI/MFLO this cycle.
- busy  output  1  operation in progress; registered.
- done  output  1  one-cycle pulse when HI/LO are written; registered.
- div_by_zero  output  1  set with done when a divide had b == 0; cleared at the next accepted start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- stall  output  1  combinational: rd_hilo & (busy | (start & ~busy)).

## Operation
- States:
  - IDLE: waits for start.
  - CALC: WIDTH iterations, one bit per cycle.
  - FIX: applies sign correction, writes HI/LO and pulses done, then returns to IDLE.
- IDLE → CALC on start, if the op is enabled.
  - Latches magnitudes of a and b. They are taken as signed for op 01/11 and unsigned otherwise.
  - Latches the result signs.
  - Loads the iteration counter with WIDTH.
- CALC, multiply: shift-add on a 2·WIDTH accumulator; unsigned magnitude product.
- CALC, divide: restoring division; unsigned quotient and remainder magnitudes.
- CALC → FIX when the counter reaches 0.
- FIX, multiply: {hi,lo} = product, negated (2·WIDTH two's complement) if the operand signs differ (signed op only).
- FIX, divide:
  - lo = quotient, negated if the operand signs differ.
  - hi = remainder, negated if the dividend is negative (remainder sign follows the dividend).
- Divide by zero runs the same latency. Result: hi = a (unmodified), lo = all ones, div_by_zero = 1.
- Signed overflow (most negative ÷ −1): lo = most negative value, hi = 0, div_by_zero = 0.
- start while busy is ignored; no queueing.
- HI/LO change only in FIX.

## Timing
- Reset (rst low, asynchronous): state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0.
  - Reset mid-operation aborts it; HI/LO read 0 afterwards.
- start sampled at edge 0:
  - busy = 1 after edge 0.
  - HI/LO written and done = 1 after edge WIDTH+1.
  - busy = 0 after edge WIDTH+1.
  - done = 0 after edge WIDTH+2.
- Back-to-back: a start in the same cycle as done is accepted, since state is IDLE then.
- stall is high from the start cycle through the last cycle busy = 1 whenever rd_hilo = 1.
  - Once released, MFHI/MFLO sees the new HI/LO.

## Configuration
- MDU_DIV_EN
  - Defined: full behaviour above.
  - Undefined:
    - Divider datapath is compiled out.
    - start with op[1] = 1 is ignored: state stays IDLE, busy/done stay 0, HI/LO unchanged, div_by_zero is constant 0.
    - Multiply ops are unaffected.

## Test plan
- MULTU, a = 0xFFFFFFFF, b = 0xFFFFFFFF, WIDTH = 32 → after edge 33: hi = 0xFFFFFFFE, lo = 0x00000001, done for exactly one cycle.
- MULT, a = 0xFFFFFFFD (−3), b = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Then DIV, a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU, a = 10, b = 0 → hi = 0x0000000A, lo = 0xFFFFFFFF, div_by_zero = 1. Next MULTU 2×3 clears the flag; hi = 0, lo = 6.
- DIV, a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_by_zero = 0.
- Busy handling:
  - start MULTU 7×6, then a second start (op 00, a = 1, b = 1) at edge 5 → ignored; result lo = 42.
  - rd_hilo held high throughout → stall = 1 from the start cycle until busy falls, 0 afterwards.
- rst pulsed low after edge 10 of a MULTU → hi = lo = 0, busy = 0, no done. A following start of 3×4 completes normally with lo = 12.
- With MDU_DIV_EN undefined: DIVU start → busy never rises, done never pulses, HI/LO unchanged.
